// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: IDCODE value, instruction encodings,
// default data-register width and the byte-transmitter state encoding.
package jtag_pkg;

    localparam int          JTAG_DEFAULT_WIDTH = 32;
    localparam logic [31:0] JTAG_IDCODE        = 32'h000FAF01;

    typedef enum logic [3:0] {
        INSTR_ABORT  = 4'b1000,
        INSTR_IDCODE = 4'b1110,
        INSTR_BYPASS = 4'b1111
    } jtag_instr_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_DONE  = 2'd2
    } tx_state_e;

    // Bit counter must reach WIDTH itself, hence the extra bit.
    function automatic int tx_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/jtag_byte_transmitter.sv
// Serialises a WIDTH-bit word onto a registered single-bit output, one bit
// per enabled TCK edge, with a sticky done flag. Drives TDO in Shift-DR.
// Build option: JTAG_BYTE_TX_MSB_FIRST_EN selects MSB-first transmission;
// without it the word goes out LSB first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// TX_IDLE  | no word captured; next enabled edge loads `in`, emits bit 0
// TX_SHIFT | word captured (busy); each enabled edge emits the next bit
// TX_DONE  | all WIDTH bits driven; done held until reset
module jtag_byte_transmitter
    import jtag_pkg::*;
#(
    parameter int WIDTH = JTAG_DEFAULT_WIDTH
) (
    input  logic             clk_tck,
    input  logic             trst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             done
);

    localparam int             CW       = tx_cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    tx_state_e        state_q;
    tx_state_e        state_d;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             load_en;
    logic             shift_en;
    logic             last_bit;

    // State register; reset aborts any word in flight.
    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: the edge that drives bit WIDTH-1 moves to TX_DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: begin
                if (load_en) begin
                    state_d = last_bit ? TX_DONE : TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (last_bit) begin
                    state_d = TX_DONE;
                end
            end
            TX_DONE: begin
                state_d = TX_DONE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Output decode: datapath strobes for load, shift and final bit.
    always_comb begin
        load_en  = 1'b0;
        shift_en = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            TX_IDLE: begin
                load_en  = enable;
                // A one-bit word finishes on its load edge.
                last_bit = enable && (WIDTH == 1);
            end
            TX_SHIFT: begin
                shift_en = enable;
                last_bit = enable && (cnt == CNT_LAST);
            end
            default: begin
                load_en  = 1'b0;
                shift_en = 1'b0;
                last_bit = 1'b0;
            end
        endcase
    end

    // Shift register, bit counter and serial output; hold when not strobed.
    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            out <= 1'b0;
            sr  <= '0;
            cnt <= '0;
        end else if (load_en) begin
`ifdef JTAG_BYTE_TX_MSB_FIRST_EN
            out <= in[WIDTH-1];
            sr  <= in << 1;
`else
            out <= in[0];
            sr  <= in >> 1;
`endif
            cnt <= CNT_ONE;
        end else if (shift_en) begin
`ifdef JTAG_BYTE_TX_MSB_FIRST_EN
            out <= sr[WIDTH-1];
            sr  <= sr << 1;
`else
            out <= sr[0];
            sr  <= sr >> 1;
`endif
            cnt <= cnt + CNT_ONE;
        end
    end

    // Sticky completion flag, raised with the last bit; only reset clears it.
    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            done <= 1'b0;
        end else if (last_bit) begin
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_byte_transmitter.sv
// Self-checking bench for jtag_byte_transmitter (WIDTH=32). The reference
// model tracks how many enabled edges have occurred since reset and picks
// the expected bit straight out of the captured word by index.
module tb_jtag_byte_transmitter;

    localparam int W = 32;

    logic         clk_tck;
    logic         trst_n;
    logic         enable;
    logic [W-1:0] in_w;
    logic         out;
    logic         done;

    int n_checks;
    int n_errors;

    int           m_cnt;
    logic [W-1:0] m_word;
    logic         m_out;
    logic         m_done;

    jtag_byte_transmitter #(.WIDTH(W)) dut (
        .clk_tck (clk_tck),
        .trst_n  (trst_n),
        .enable  (enable),
        .in      (in_w),
        .out     (out),
        .done    (done)
    );

    initial clk_tck = 1'b0;
    always #5 clk_tck = ~clk_tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_word = '0;
        m_out  = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [W-1:0] din);
        if (en && m_cnt < W) begin
            if (m_cnt == 0) m_word = din;
`ifdef JTAG_BYTE_TX_MSB_FIRST_EN
            m_out = m_word[W-1-m_cnt];
`else
            m_out = m_word[m_cnt];
`endif
            m_cnt++;
            m_done = (m_cnt == W);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check after it.
    task automatic tick(input string tag, input logic en, input logic [W-1:0] din);
        enable = en;
        in_w   = din;
        @(posedge clk_tck);
        model_edge(en, din);
        #1;
        chk({tag, ".out"}, {31'd0, out}, {31'd0, m_out});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, m_done});
    endtask

    // Reset asserted between edges; outputs must clear without an edge.
    task automatic async_reset(input string tag);
        #2;
        trst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".rst_out"}, {31'd0, out}, 32'd0);
        chk({tag, ".rst_done"}, {31'd0, done}, 32'd0);
        #1;
        trst_n = 1'b1;
    endtask

    // Run one word with a given enable duty; bounded in cycles.
    task automatic run_word(input string tag, input logic [W-1:0] word, input int gap_mode);
        int  guard;
        logic en;
        guard = 0;
        while (!m_done && guard < 400) begin
            case (gap_mode)
                0:       en = 1'b1;
                1:       en = (guard % 2 == 0);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            tick(tag, en, word);
            guard++;
        end
        if (!m_done) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [W-1:0] idcode_bits;
        int           en_edges;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        enable = 1'b1;
        in_w   = 32'h000F_AF01;
        trst_n = 1'b0;

        // Reset held for 3 clocks with enable high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_tck);
            #1;
            chk("rst_hold.out", {31'd0, out}, 32'd0);
            chk("rst_hold.done", {31'd0, done}, 32'd0);
        end
        trst_n = 1'b1;

`ifndef JTAG_BYTE_TX_MSB_FIRST_EN
        // IDCODE, continuous enable, against the literal bit sequence too.
        idcode_bits = 32'h000F_AF01;
        for (int k = 0; k < W; k++) begin
            tick("idcode", 1'b1, 32'h000F_AF01);
            chk("idcode.lit", {31'd0, out}, {31'd0, idcode_bits[k]});
            chk("idcode.done_lit", {31'd0, done}, (k == W - 1) ? 32'd1 : 32'd0);
        end
`else
        idcode_bits = 32'h0;
        run_word("idcode", 32'h000F_AF01, 0);
`endif

        // Post-done hold with a changed input word.
        for (int i = 0; i < 10; i++) tick("post_done", 1'b1, 32'hFFFF_FFFF);
        async_reset("post_done");
        tick("restart", 1'b1, 32'h0000_0002);
        run_word("restart", 32'h0000_0002, 0);

        // Gapped enable 1,0,1,0: count enabled edges to done.
        async_reset("gap");
        en_edges = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick("gap", (i % 2 == 0), 32'hA5A5_A5A5);
            if (i % 2 == 0) en_edges++;
        end
        chk("gap.edges", en_edges, W);
        chk("gap.done_final", {31'd0, done}, 32'd1);

        // Mid-word abort then a fresh word.
        async_reset("abort");
        for (int i = 0; i < 5; i++) tick("abort_pre", 1'b1, 32'hFFFF_FFFF);
        async_reset("abort");
        run_word("abort_post", 32'h0000_0001, 0);

        // Inputs changed after load must be ignored.
        async_reset("chg");
        tick("chg", 1'b1, 32'h1234_5678);
        model_edge(1'b0, '0);
        for (int i = 1; i < W; i++) begin
            enable = 1'b1;
            in_w   = $urandom;
            @(posedge clk_tck);
            model_edge(1'b1, in_w);
            #1;
            chk("chg.out", {31'd0, out}, {31'd0, m_out});
            chk("chg.done", {31'd0, done}, {31'd0, m_done});
        end

`ifdef JTAG_BYTE_TX_MSB_FIRST_EN
        async_reset("msb");
        for (int k = 0; k < W; k++) begin
            tick("msb", 1'b1, 32'h8000_0000);
            chk("msb.lit", {31'd0, out}, (k == 0) ? 32'd1 : 32'd0);
        end
`endif

        // Randomized words with random enable duty.
        for (int r = 0; r < 6; r++) begin
            async_reset("rand");
            run_word("rand", $urandom, 2);
            for (int i = 0; i < 3; i++) tick("rand_hold", $urandom_range(0, 1) == 1, $urandom);
        end

        // Reset mid-word during random duty.
        async_reset("rand_abort");
        for (int i = 0; i < 7; i++) tick("rand_abort", $urandom_range(0, 1) == 1, 32'hDEAD_BEEF);
        async_reset("rand_abort");
        run_word("rand_abort", $urandom, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
